// File: rtl/proc_pipe_param.sv
// -----------------------------------------------------------------------------
// proc_pipe_param
// Four-stage (fetch / decode / execute / writeback) pipelined core executing
// add-immediate, subtract-immediate, NOP and HALT. Operands are forwarded from
// X and W into D so dependent instructions issue back to back without stalls.
// Optional unsigned saturation, write protection of register 0, an external
// stall input and a counter of committed register writes.
//
// Instruction word (MSB -> LSB): op[2] | rd[REG_ADDR_WIDTH] | rs[REG_ADDR_WIDTH]
//                                | imm[DATA_WIDTH]
//   op: 00 ADDI rd=rs+imm, 01 SUBI rd=rs-imm, 10 NOP, 11 HALT
//
// Ports:
//   clock            in   master clock, rising edge
//   reset            in   synchronous, active-low
//   stall            in   freezes every state element while high
//   address_imem     out  program counter (registered)
//   q_imem           in   instruction at address_imem, same cycle
//   ctrl_readReg     out  rs of the instruction in D
//   data_readReg     in   register file read data for ctrl_readReg
//   ctrl_writeEnable out  register file write strobe (W stage)
//   ctrl_writeReg    out  rd of the instruction in W
//   data_writeReg    out  result of the instruction in W
//   halted           out  sticky, set when HALT reaches W
//   retire_count     out  number of committed register writes (wraps)
// -----------------------------------------------------------------------------
module proc_pipe_param #(
   parameter int DATA_WIDTH      = 8,
   parameter int REG_ADDR_WIDTH  = 3,
   parameter int IMEM_ADDR_WIDTH = 8,
   parameter int SATURATE        = 0,
   parameter int ZERO_REG        = 1,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                                          clock,
   input  logic                                          reset,
   input  logic                                          stall,
   output logic [IMEM_ADDR_WIDTH-1:0]                    address_imem,
   input  logic [2+2*REG_ADDR_WIDTH+DATA_WIDTH-1:0]      q_imem,
   output logic [REG_ADDR_WIDTH-1:0]                     ctrl_readReg,
   input  logic [DATA_WIDTH-1:0]                         data_readReg,
   output logic                                          ctrl_writeEnable,
   output logic [REG_ADDR_WIDTH-1:0]                     ctrl_writeReg,
   output logic [DATA_WIDTH-1:0]                         data_writeReg,
   output logic                                          halted,
   output logic [CNT_WIDTH-1:0]                          retire_count
);

   localparam int INSN_WIDTH = 2 + 2*REG_ADDR_WIDTH + DATA_WIDTH;

   localparam logic [1:0] OP_ADDI = 2'b00;
   localparam logic [1:0] OP_SUBI = 2'b01;
   localparam logic [1:0] OP_NOP  = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   localparam logic [INSN_WIDTH-1:0] INSN_NOP = {OP_NOP, {(INSN_WIDTH-2){1'b0}}};

   // ---------------------------------------------------------------- state
   logic [IMEM_ADDR_WIDTH-1:0] r_pc;
   logic                       r_halt_seen;
   logic                       r_halted;
   logic [CNT_WIDTH-1:0]       r_cnt;

   // F/D: full instruction
   logic [INSN_WIDTH-1:0]      r_fd_insn;

   // D/X: the fields execute still needs, plus operand A
   logic [1:0]                 r_dx_op;
   logic [REG_ADDR_WIDTH-1:0]  r_dx_rd;
   logic [DATA_WIDTH-1:0]      r_dx_imm;
   logic [DATA_WIDTH-1:0]      r_dx_a;

   // X/W: the fields writeback still needs, plus the result
   logic [1:0]                 r_xw_op;
   logic [REG_ADDR_WIDTH-1:0]  r_xw_rd;
   logic [DATA_WIDTH-1:0]      r_xw_res;

   // ---------------------------------------------------------------- decode
   logic [1:0]                 w_fd_op;
   logic [REG_ADDR_WIDTH-1:0]  w_fd_rd;
   logic [REG_ADDR_WIDTH-1:0]  w_fd_rs;
   logic [DATA_WIDTH-1:0]      w_fd_imm;
   logic [1:0]                 w_q_op;

   assign w_fd_op  = r_fd_insn[INSN_WIDTH-1 -: 2];
   assign w_fd_rd  = r_fd_insn[INSN_WIDTH-3 -: REG_ADDR_WIDTH];
   assign w_fd_rs  = r_fd_insn[DATA_WIDTH+REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
   assign w_fd_imm = r_fd_insn[DATA_WIDTH-1:0];
   assign w_q_op   = q_imem[INSN_WIDTH-1 -: 2];

   // ADDI and SUBI are the only writers; both have op[1] clear.
   logic w_dx_writes;
   logic w_xw_writes;
   assign w_dx_writes = (r_dx_op == OP_ADDI) || (r_dx_op == OP_SUBI);
   assign w_xw_writes = (r_xw_op == OP_ADDI) || (r_xw_op == OP_SUBI);

   // With register 0 protected, reads of r0 must see the register file's
   // constant zero and never a forwarded (discarded) result.
   logic w_rs_is_zero;
   logic w_xw_rd_is_zero;
   assign w_rs_is_zero    = (ZERO_REG != 0) && (w_fd_rs == '0);
   assign w_xw_rd_is_zero = (ZERO_REG != 0) && (r_xw_rd == '0);

   // ---------------------------------------------------------------- execute
   logic [DATA_WIDTH-1:0] w_add_res;
   logic [DATA_WIDTH-1:0] w_sub_res;
   logic [DATA_WIDTH-1:0] w_alu;

   generate
      if (SATURATE != 0) begin : g_sat
         logic [DATA_WIDTH:0] w_sum;
         logic [DATA_WIDTH:0] w_diff;
         assign w_sum  = {1'b0, r_dx_a} + {1'b0, r_dx_imm};
         assign w_diff = {1'b0, r_dx_a} - {1'b0, r_dx_imm};
         // Carry out clamps high; borrow (MSB of the widened difference) clamps low.
         assign w_add_res = w_sum[DATA_WIDTH]  ? {DATA_WIDTH{1'b1}} : w_sum[DATA_WIDTH-1:0];
         assign w_sub_res = w_diff[DATA_WIDTH] ? {DATA_WIDTH{1'b0}} : w_diff[DATA_WIDTH-1:0];
      end else begin : g_wrap
         assign w_add_res = r_dx_a + r_dx_imm;
         assign w_sub_res = r_dx_a - r_dx_imm;
      end
   endgenerate

   assign w_alu = (r_dx_op == OP_SUBI) ? w_sub_res : w_add_res;

   // ---------------------------------------------------------------- operand A
   // The youngest producer wins: X (instruction i-1) before W (i-2) before
   // the register file (i-3 or older, already committed).
   logic w_fwd_x;
   logic w_fwd_w;
   logic [DATA_WIDTH-1:0] w_opnd_a;

   assign w_fwd_x = w_dx_writes && (r_dx_rd == w_fd_rs) && !w_rs_is_zero;
   assign w_fwd_w = w_xw_writes && (r_xw_rd == w_fd_rs) && !w_rs_is_zero;

   always_comb begin
      w_opnd_a = data_readReg;
      if (w_fwd_x) begin
         w_opnd_a = w_alu;
      end else if (w_fwd_w) begin
         w_opnd_a = r_xw_res;
      end
   end

   // ---------------------------------------------------------------- writeback
   // Blocking the strobe during stall keeps the W instruction pending, so it
   // commits exactly once: on the first unstalled cycle.
   logic w_write_en;
   assign w_write_en = w_xw_writes && !stall && !w_xw_rd_is_zero;

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_pc        <= '0;
         r_halt_seen <= 1'b0;
         r_halted    <= 1'b0;
         r_cnt       <= '0;
         r_fd_insn   <= INSN_NOP;
         r_dx_op     <= OP_NOP;
         r_dx_rd     <= '0;
         r_dx_imm    <= '0;
         r_dx_a      <= '0;
         r_xw_op     <= OP_NOP;
         r_xw_rd     <= '0;
         r_xw_res    <= '0;
      end else if (!stall) begin
         // Fetch: once HALT has been latched, freeze the PC and feed bubbles.
         if (r_halt_seen) begin
            r_fd_insn <= INSN_NOP;
         end else begin
            r_pc      <= r_pc + IMEM_ADDR_WIDTH'(1);
            r_fd_insn <= q_imem;
            if (w_q_op == OP_HALT) begin
               r_halt_seen <= 1'b1;
            end
         end

         r_dx_op  <= w_fd_op;
         r_dx_rd  <= w_fd_rd;
         r_dx_imm <= w_fd_imm;
         r_dx_a   <= w_opnd_a;

         r_xw_op  <= r_dx_op;
         r_xw_rd  <= r_dx_rd;
         r_xw_res <= w_alu;

         // Set on the edge that moves HALT into X/W, so the flag is high
         // in the same cycle HALT occupies W.
         if (r_dx_op == OP_HALT) begin
            r_halted <= 1'b1;
         end

         if (w_write_en) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   assign address_imem     = r_pc;
   assign ctrl_readReg     = w_fd_rs;
   assign ctrl_writeEnable = w_write_en;
   assign ctrl_writeReg    = r_xw_rd;
   assign data_writeReg    = r_xw_res;
   assign halted           = r_halted;
   assign retire_count     = r_cnt;

endmodule

// File: tb/tb_proc_pipe_param.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for proc_pipe_param. A wrap-around instance and
// a saturating instance run the same program from a shared instruction memory;
// each has its own behavioural register file.
// -----------------------------------------------------------------------------
module tb_proc_pipe_param;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic stall = 1'b0;

   always #5 clock = ~clock;

   // wrap-around instance
   logic [7:0]  address_imem;
   logic [15:0] q_imem;
   logic [2:0]  ctrl_readReg;
   logic [7:0]  data_readReg;
   logic        ctrl_writeEnable;
   logic [2:0]  ctrl_writeReg;
   logic [7:0]  data_writeReg;
   logic        halted;
   logic [15:0] retire_count;

   // saturating instance
   logic [7:0]  s_addr;
   logic [15:0] s_q;
   logic [2:0]  s_rreg;
   logic [7:0]  s_rdata;
   logic        s_we;
   logic [2:0]  s_wreg;
   logic [7:0]  s_wdata;
   logic        s_halted;
   logic [15:0] s_cnt;

   logic [15:0] imem [256];
   logic [7:0]  rf   [8];
   logic [7:0]  rf_s [8];

   assign q_imem       = imem[address_imem];
   assign data_readReg = rf[ctrl_readReg];
   assign s_q          = imem[s_addr];
   assign s_rdata      = rf_s[s_rreg];

   proc_pipe_param dut (
      .clock            (clock),
      .reset            (reset),
      .stall            (stall),
      .address_imem     (address_imem),
      .q_imem           (q_imem),
      .ctrl_readReg     (ctrl_readReg),
      .data_readReg     (data_readReg),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .halted           (halted),
      .retire_count     (retire_count)
   );

   proc_pipe_param #(.SATURATE(1)) dut_sat (
      .clock            (clock),
      .reset            (reset),
      .stall            (stall),
      .address_imem     (s_addr),
      .q_imem           (s_q),
      .ctrl_readReg     (s_rreg),
      .data_readReg     (s_rdata),
      .ctrl_writeEnable (s_we),
      .ctrl_writeReg    (s_wreg),
      .data_writeReg    (s_wdata),
      .halted           (s_halted),
      .retire_count     (s_cnt)
   );

   // cycle numbering: the first cycle with reset=1 is cycle 0
   int cyc;
   int wl_cyc[$];
   int wl_reg[$];
   int wl_dat[$];

   always @(posedge clock) begin
      if (!reset) begin
         cyc <= 0;
         for (int i = 0; i < 8; i++) begin
            rf[i]   <= 8'd0;
            rf_s[i] <= 8'd0;
         end
         wl_cyc.delete();
         wl_reg.delete();
         wl_dat.delete();
      end else begin
         cyc <= cyc + 1;
         if (ctrl_writeEnable) begin
            rf[ctrl_writeReg] <= data_writeReg;
            wl_cyc.push_back(cyc);
            wl_reg.push_back(int'(ctrl_writeReg));
            wl_dat.push_back(int'(data_writeReg));
            $display("write cycle=%0d r%0d=%0d", cyc, ctrl_writeReg, data_writeReg);
         end
         if (s_we) begin
            rf_s[s_wreg] <= s_wdata;
         end
      end
   end

   int total = 0;
   int bad   = 0;
   int cur   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_w(input string tag, input int idx, input int c, input int r, input int d);
      int gc, gr, gd;
      gc = -1; gr = -1; gd = -1;
      if (idx < wl_cyc.size()) begin
         gc = wl_cyc[idx];
         gr = wl_reg[idx];
         gd = wl_dat[idx];
      end
      chk($sformatf("%s_w%0d_cyc", tag, idx), gc, c);
      chk($sformatf("%s_w%0d_reg", tag, idx), gr, r);
      chk($sformatf("%s_w%0d_dat", tag, idx), gd, d);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      cur++;
   endtask

   task automatic start();
      reset = 1'b0;
      stall = 1'b0;
      step();
      reset = 1'b1;
      #1;
      cur = 0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_addr"},  address_imem, 0);
      chk({tag, "_we"},    ctrl_writeEnable, 0);
      chk({tag, "_wreg"},  ctrl_writeReg, 0);
      chk({tag, "_wdata"}, data_writeReg, 0);
      chk({tag, "_rreg"},  ctrl_readReg, 0);
      chk({tag, "_halt"},  halted, 0);
      chk({tag, "_cnt"},   retire_count, 0);
   endtask

   function automatic logic [15:0] enc(input logic [1:0] op, input int rd, input int rs, input int imm);
      logic [2:0] d;
      logic [2:0] s;
      logic [7:0] m;
      d = rd[2:0];
      s = rs[2:0];
      m = imm[7:0];
      return {op, d, s, m};
   endfunction

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) imem[i] = 16'h8000;
   endtask

   int exp_w [4];
   int exp_s [4];
   int exp_r [4];

   initial begin
      // ---- single ADDI: first write lands in cycle 3
      $display("case basic_addi");
      clear_prog();
      imem[0] = enc(2'b00, 1, 0, 5);
      start();
      chk_reset_state("rst");
      step(); step();
      chk("basic_we_c2", ctrl_writeEnable, 0);
      step();
      chk("basic_we_c3", ctrl_writeEnable, 1);
      chk("basic_wreg_c3", ctrl_writeReg, 1);
      chk("basic_wdata_c3", data_writeReg, 5);
      chk("basic_addr_c3", address_imem, 3);
      step();
      chk("basic_we_c4", ctrl_writeEnable, 0);
      chk("basic_cnt_c4", retire_count, 1);

      // ---- PC wraps after 256 fetches
      $display("case pc_wrap");
      clear_prog();
      start();
      repeat (256) step();
      chk("wrap_addr0", address_imem, 0);
      step();
      chk("wrap_addr1", address_imem, 1);
      chk("wrap_halt", halted, 0);

      // ---- dependent chain with X, W and regfile sourcing
      $display("case dep_chain");
      clear_prog();
      imem[0] = enc(2'b00, 1, 0, 3);
      imem[1] = enc(2'b00, 2, 1, 4);
      imem[2] = enc(2'b00, 3, 2, 1);
      imem[3] = enc(2'b01, 4, 1, 1);
      imem[5] = enc(2'b00, 5, 4, 10);
      start();
      repeat (10) step();
      chk("chain_nw", wl_cyc.size(), 5);
      chk_w("chain", 0, 3, 1, 3);
      chk_w("chain", 1, 4, 2, 7);
      chk_w("chain", 2, 5, 3, 8);
      chk_w("chain", 3, 6, 4, 2);
      chk_w("chain", 4, 8, 5, 12);
      chk("chain_cnt", retire_count, 5);

      // ---- overflow / underflow, wrap vs saturate instance
      $display("case overflow");
      clear_prog();
      imem[0] = enc(2'b00, 1, 0, 200);
      imem[1] = enc(2'b00, 1, 1, 100);
      imem[2] = enc(2'b00, 1, 1, 1);
      imem[3] = enc(2'b01, 2, 0, 1);
      exp_r = '{1, 1, 1, 2};
      exp_w = '{200, 44, 45, 255};
      exp_s = '{200, 255, 255, 0};
      start();
      repeat (3) step();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ovf_we_%0d", k),      ctrl_writeEnable, 1);
         chk($sformatf("ovf_wreg_%0d", k),    ctrl_writeReg, exp_r[k]);
         chk($sformatf("ovf_wdata_%0d", k),   data_writeReg, exp_w[k]);
         chk($sformatf("ovf_s_we_%0d", k),    s_we, 1);
         chk($sformatf("ovf_s_wdata_%0d", k), s_wdata, exp_s[k]);
         step();
      end

      // ---- register 0 protection
      $display("case zero_reg");
      clear_prog();
      imem[0] = enc(2'b00, 0, 0, 9);
      imem[1] = enc(2'b00, 1, 0, 1);
      start();
      repeat (6) step();
      chk("zero_nw", wl_cyc.size(), 1);
      chk_w("zero", 0, 4, 1, 1);
      chk("zero_cnt", retire_count, 1);

      // ---- HALT
      $display("case halt");
      clear_prog();
      imem[0] = enc(2'b00, 1, 0, 1);
      imem[1] = enc(2'b11, 0, 0, 0);
      imem[2] = enc(2'b00, 2, 0, 2);
      start();
      step(); step();
      chk("halt_addr_c2", address_imem, 2);
      step();
      chk("halt_flag_c3", halted, 0);
      step();
      chk("halt_flag_c4", halted, 1);
      repeat (4) step();
      chk("halt_flag_c8", halted, 1);
      chk("halt_addr_c8", address_imem, 2);
      chk("halt_nw", wl_cyc.size(), 1);
      chk_w("halt", 0, 3, 1, 1);
      chk("halt_cnt", retire_count, 1);

      // ---- stall for cycles 3..5 while ADDI sits in W
      $display("case stall");
      clear_prog();
      imem[0] = enc(2'b00, 1, 0, 6);
      start();
      repeat (3) step();
      stall = 1'b1;
      #1;
      chk("stall_we_c3", ctrl_writeEnable, 0);
      step();
      chk("stall_we_c4", ctrl_writeEnable, 0);
      chk("stall_wreg_c4", ctrl_writeReg, 1);
      step();
      chk("stall_we_c5", ctrl_writeEnable, 0);
      chk("stall_cnt_c5", retire_count, 0);
      step();
      stall = 1'b0;
      #1;
      chk("stall_we_c6", ctrl_writeEnable, 1);
      chk("stall_wdata_c6", data_writeReg, 6);
      chk("stall_addr_c6", address_imem, 3);
      step();
      chk("stall_we_c7", ctrl_writeEnable, 0);
      chk("stall_cnt_c7", retire_count, 1);
      chk("stall_nw", wl_cyc.size(), 1);

      // ---- reset mid-chain
      $display("case reset_mid");
      clear_prog();
      imem[0] = enc(2'b00, 1, 0, 3);
      imem[1] = enc(2'b00, 2, 1, 4);
      imem[2] = enc(2'b00, 3, 2, 1);
      imem[3] = enc(2'b01, 4, 1, 1);
      start();
      repeat (4) step();
      chk("mid_cnt_before", retire_count, 1);
      start();
      chk_reset_state("mid");
      step();
      chk("mid_we_c1", ctrl_writeEnable, 0);
      step();
      chk("mid_we_c2", ctrl_writeEnable, 0);
      repeat (5) step();
      chk("mid_nw", wl_cyc.size(), 4);
      chk_w("mid", 0, 3, 1, 3);
      chk_w("mid", 3, 6, 4, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
